// File: rtl/bus_xfer_pkg.sv
// rtl/bus_xfer_pkg.sv - shared types and constants for the byte-bus transfer sequencer
//
// Contents:
//   DATA_W_DEF : default bus data width
//   state_t    : sequencer state (IDLE, DRIVE)
//   chan_t     : 1-bit source / destination index
package bus_xfer_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

  typedef logic chan_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational 2-way round-robin arbiter
//
// Ports:
//   req       in  [1:0] request lines, bit N = source N
//   rr        in  chan_t source favoured when both request
//   grant_vld out 1     at least one source is requesting
//   grant     out chan_t winning source (0 when grant_vld=0)
module rr_arb2
  import bus_xfer_pkg::*;
(
  input  logic [1:0] req,
  input  chan_t      rr,
  output logic       grant_vld,
  output chan_t      grant
);

  always_comb begin
    grant_vld = |req;
    grant     = 1'b0;
    case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = rr;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// rtl/bus_xfer_ctrl.sv - 2-source / 2-destination byte-bus transfer sequencer
//
// Parameters:
//   DATA_W  : bus data width
//   TIMEOUT : DRIVE cycles without ready before the transfer is dropped (0 = never)
// Optional build macro:
//   BUS_XFER_CTRL_PARITY_EN : adds out0_par / out1_par (even parity of outN while valid)
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   reqN, dstN, dataN       : source N request, destination select, byte
//   ackN                    : one-cycle pulse, source N byte captured
//   outN, outN_vld, outN_rdy: destination N data / valid / ready
//   busy                    : high while a transfer is being driven
//   err                     : one-cycle pulse, transfer dropped on timeout
module bus_xfer_ctrl
  import bus_xfer_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              dst0,
  input  logic [DATA_W-1:0] data0,
  output logic              ack0,
  input  logic              req1,
  input  logic              dst1,
  input  logic [DATA_W-1:0] data1,
  output logic              ack1,
  output logic [DATA_W-1:0] out0,
  output logic              out0_vld,
  input  logic              out0_rdy,
  output logic [DATA_W-1:0] out1,
  output logic              out1_vld,
  input  logic              out1_rdy,
  output logic              busy,
  output logic              err
`ifdef BUS_XFER_CTRL_PARITY_EN
  ,
  output logic              out0_par,
  output logic              out1_par
`endif
);

  // Timer only needs to reach TIMEOUT-1; keep at least one bit so TIMEOUT of 0/1 still elaborates.
  localparam int              TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]   TLIM = TW'(TIMEOUT - 1);

  state_t            state, state_nxt;
  chan_t             rr, rr_nxt;
  chan_t             grant;
  logic              grant_vld;
  logic [DATA_W-1:0] hold_data, hold_data_nxt;
  chan_t             hold_dst, hold_dst_nxt;
  logic [TW-1:0]     timer, timer_nxt;

  logic              ack0_nxt, ack1_nxt, err_nxt, busy_nxt;
  logic              out0_vld_nxt, out1_vld_nxt;
  logic [DATA_W-1:0] out0_nxt, out1_nxt;

  logic              sel_vld, sel_rdy, done, tmo, timeout_hit;

  rr_arb2 u_arb (
    .req       ({req1, req0}),
    .rr        (rr),
    .grant_vld (grant_vld),
    .grant     (grant)
  );

  // Only the destination currently being driven is allowed to complete the handshake.
  assign sel_vld     = hold_dst ? out1_vld : out0_vld;
  assign sel_rdy     = hold_dst ? out1_rdy : out0_rdy;
  assign timeout_hit = (TIMEOUT != 0) && (timer == TLIM);
  assign done        = (state == DRIVE) && sel_vld && sel_rdy;
  // Ready on the last allowed cycle beats the timeout.
  assign tmo         = (state == DRIVE) && !sel_rdy && timeout_hit;

  // State register (plus registered datapath and outputs)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr        <= 1'b0;
      hold_data <= '0;
      hold_dst  <= 1'b0;
      timer     <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      out0      <= '0;
      out1      <= '0;
      out0_vld  <= 1'b0;
      out1_vld  <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      rr        <= rr_nxt;
      hold_data <= hold_data_nxt;
      hold_dst  <= hold_dst_nxt;
      timer     <= timer_nxt;
      ack0      <= ack0_nxt;
      ack1      <= ack1_nxt;
      out0      <= out0_nxt;
      out1      <= out1_nxt;
      out0_vld  <= out0_vld_nxt;
      out1_vld  <= out1_vld_nxt;
      busy      <= busy_nxt;
      err       <= err_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_vld) state_nxt = DRIVE;
      DRIVE:   if (done || tmo) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    rr_nxt        = rr;
    hold_data_nxt = hold_data;
    hold_dst_nxt  = hold_dst;
    timer_nxt     = timer;
    ack0_nxt      = 1'b0;
    ack1_nxt      = 1'b0;
    err_nxt       = 1'b0;
    out0_nxt      = out0;
    out1_nxt      = out1;
    out0_vld_nxt  = out0_vld;
    out1_vld_nxt  = out1_vld;
    busy_nxt      = (state_nxt == DRIVE);

    case (state)
      IDLE: begin
        if (grant_vld) begin
          hold_data_nxt = grant ? data1 : data0;
          hold_dst_nxt  = grant ? dst1 : dst0;
          ack0_nxt      = (grant == 1'b0);
          ack1_nxt      = (grant == 1'b1);
          rr_nxt        = ~grant;
          timer_nxt     = '0;
          // Drive the destination straight from the captured source so vld rises with ack.
          if (hold_dst_nxt) begin
            out1_nxt     = hold_data_nxt;
            out1_vld_nxt = 1'b1;
          end else begin
            out0_nxt     = hold_data_nxt;
            out0_vld_nxt = 1'b1;
          end
        end
      end
      DRIVE: begin
        if (done || tmo) begin
          out0_nxt     = '0;
          out1_nxt     = '0;
          out0_vld_nxt = 1'b0;
          out1_vld_nxt = 1'b0;
          err_nxt      = tmo;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      default: begin
        out0_nxt     = '0;
        out1_nxt     = '0;
        out0_vld_nxt = 1'b0;
        out1_vld_nxt = 1'b0;
      end
    endcase
  end

`ifdef BUS_XFER_CTRL_PARITY_EN
  // Parity is computed from the next data so it changes on the same edge as outN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0_par <= 1'b0;
      out1_par <= 1'b0;
    end else begin
      out0_par <= out0_vld_nxt & (^out0_nxt);
      out1_par <= out1_vld_nxt & (^out1_nxt);
    end
  end
`endif

endmodule
